// File: rtl/decoder_pkg.sv
// Shared types and decode function for the registered 2-to-4 decoder.
//
// Contents:
//   SEL_W, OUT_W    - select width (2) and output width (4)
//   sel_t           - 2-bit select index {h1,h0}
//   onehot_t        - 4-bit output vector {u3,u2,u1,u0}
//   onehot_decode() - enable-gated one-hot decode of a select index
package decoder_pkg;

    localparam int SEL_W = 2;
    localparam int OUT_W = 4;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    // Every path starts from all-zero and sets at most one bit.
    // An unknown enable falls through the if, and an unknown select
    // matches no case item, so X/Z inputs decode to zero rather than
    // to a multi-hot pattern.
    function automatic onehot_t onehot_decode(sel_t s, logic en);
        onehot_t r;
        r = '0;
        if (en) begin
            case (s)
                2'd0:    r = 4'b0001;
                2'd1:    r = 4'b0010;
                2'd2:    r = 4'b0100;
                2'd3:    r = 4'b1000;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational core of the decoder: turns an enable and a 2-bit select
// into a one-hot (or all-zero) 4-bit vector.
//
// Ports:
//   en     in   enable, active-high
//   sel    in   select index, bit 1 = MSB
//   onehot out  one-hot vector, all zero when disabled
module decoder_onehot
    import decoder_pkg::*;
(
    input  logic    en,
    input  sel_t    sel,
    output onehot_t onehot
);

    always_comb begin
        onehot = '0;
        onehot = onehot_decode(sel, en);
    end

endmodule

// File: rtl/decoder.sv
// Registered 2-to-4 line decoder with active-high enable.
// Outputs update one cycle after the inputs are sampled and are cleared
// by a synchronous active-low reset that overrides enable and select.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous reset, active-low
//   e      in   enable, active-high
//   h0     in   select bit 0 (LSB)
//   h1     in   select bit 1 (MSB)
//   u0..u3 out  registered one-hot outputs, u[{h1,h0}] high when enabled
module decoder
    import decoder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic e,
    input  logic h0,
    input  logic h1,
    output logic u0,
    output logic u1,
    output logic u2,
    output logic u3
);

    sel_t    sel_next;
    onehot_t onehot_next;
    onehot_t onehot_reg;

    assign sel_next = {h1, h0};

    decoder_onehot u_onehot (
        .en     (e),
        .sel    (sel_next),
        .onehot (onehot_next)
    );

    // The register is the only state; reset clears it outright so no
    // stale one-hot value survives a mid-operation reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            onehot_reg <= '0;
        end else begin
            onehot_reg <= onehot_next;
        end
    end

    assign u0 = onehot_reg[0];
    assign u1 = onehot_reg[1];
    assign u2 = onehot_reg[2];
    assign u3 = onehot_reg[3];

`ifndef SYNTHESIS
    // At most one output may be high at any clock edge.
    onehot_or_zero_a : assert property (@(posedge clk) $onehot0({u3, u2, u1, u0}));
`endif

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for the registered 2-to-4 decoder.
// The driver applies inputs on the falling edge and queues the output
// vector expected after the next rising edge; the monitor pops one entry
// per rising edge and compares it against {u3,u2,u1,u0}.
module tb_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic e;
    logic h0;
    logic h1;
    logic u0;
    logic u1;
    logic u2;
    logic u3;

    typedef struct {
        logic [3:0] exp;
        string      tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .h0    (h0),
        .h1    (h1),
        .u0    (u0),
        .u1    (u1),
        .u2    (u2),
        .u3    (u3)
    );

    // Reference behaviour used for the random phase.
    function automatic logic [3:0] ref_model(logic r, logic en, logic a1, logic a0);
        logic [3:0] v;
        v = 4'b0000;
        if (r && en) begin
            case ({a1, a0})
                2'b00:   v = 4'b0001;
                2'b01:   v = 4'b0010;
                2'b10:   v = 4'b0100;
                default: v = 4'b1000;
            endcase
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: u3..u0=%b required %b", tag, act, exp);
        end else begin
            $display("ok   %s: u3..u0=%b", tag, act);
        end
    endtask

    task automatic apply(input logic r, input logic en, input logic a1, input logic a0,
                         input logic [3:0] exp, input string tag);
        sb_entry_t ent;
        @(negedge clk);
        rst_n = r;
        e     = en;
        h1    = a1;
        h0    = a0;
        ent.exp = exp;
        ent.tag = tag;
        sb_q.push_back(ent);
    endtask

    // Monitor: one comparison per rising edge that has an outstanding
    // expectation, plus the one-hot-or-zero invariant on that edge.
    initial begin : monitor
        sb_entry_t ent;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                ent = sb_q.pop_front();
                check(ent.tag, {u3, u2, u1, u0}, ent.exp);
                n_checks++;
                if (!$onehot0({u3, u2, u1, u0})) begin
                    n_fail++;
                    $display("FAIL onehot0_%s: u3..u0=%b required at most one bit high",
                             ent.tag, {u3, u2, u1, u0});
                end
            end
        end
    end

    initial begin : driver
        logic r;
        logic en;
        logic a1;
        logic a0;

        rst_n = 1'b0;
        e     = 1'b0;
        h0    = 1'b0;
        h1    = 1'b0;

        // Reset held two cycles with a live select, then released.
        apply(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, "reset_hold0");
        apply(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, "reset_hold1");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, "reset_release");

        // Disabled with select 11.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, "disabled_11");

        // Enabled sweep.
        apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, "sweep_00");
        apply(1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, "sweep_01");
        apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, "sweep_10");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, "sweep_11");

        // Latency: a mid-cycle select change must not reach the outputs
        // before the next rising edge.
        apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, "latency_pre");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, "latency_post");
        #1;
        check("latency_hold", {u3, u2, u1, u0}, 4'b0001);

        // Reset pulse in mid-operation, inputs left unchanged.
        apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, "midrst_pre");
        apply(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, "midrst_pulse");
        apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, "midrst_post");

        // Random phase, reset asserted about one cycle in eight.
        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(7) != 0);
            en = 1'($urandom_range(1));
            a1 = 1'($urandom_range(1));
            a0 = 1'($urandom_range(1));
            apply(r, en, a1, a0, ref_model(r, en, a1, a0), $sformatf("rand%0d", i));
        end

        // Drain the scoreboard within a bounded number of cycles.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
